// File: rtl/stdp_synapse_array.sv
// Multi-channel STDP synapse array: per-channel pre-traces and weights, one shared post-trace,
// event-flagged weight updates applied by a sequential scan. Optional host write port: STDP_WLOAD_EN.
module stdp_synapse_array #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 12,
  parameter int FRAC        = 5,
  parameter int W_INIT      = 32,
  parameter int TRACE_INC   = 16,
  parameter int DECAY_SHIFT = 3,
  parameter int LR_SHIFT    = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_CH-1:0]                 pre_spike,
  input  logic                            post_spike,
  output logic [WIDTH+$clog2(N_CH)-1:0]   i_syn,
  output logic                            busy,
  input  logic [$clog2(N_CH)-1:0]         rd_sel,
  output logic [WIDTH-2:0]                rd_weight,
  input  logic                            wr_en,
  input  logic [$clog2(N_CH)-1:0]         wr_sel,
  input  logic [WIDTH-2:0]                wr_data
);

  localparam int SW = $clog2(N_CH);
  localparam int TW = WIDTH - 1;
  localparam int OW = WIDTH + SW;
  localparam int PW = 2 * TW;
  localparam int SH = FRAC + LR_SHIFT;

  typedef logic [TW-1:0]        val_t;
  typedef logic [TW:0]          ext_t;
  typedef logic [PW-1:0]        prod_t;
  typedef logic signed [PW+1:0] acc_t;
  typedef logic [OW-1:0]        sum_t;
  typedef logic [SW-1:0]        sel_t;

  typedef enum logic {IDLE, SCAN} state_t;

  localparam sel_t LAST  = sel_t'(N_CH - 1);
  localparam val_t W_MAX = '1;

  state_t          state, state_nxt;
  sel_t            idx, idx_nxt;
  val_t            weight     [N_CH];
  val_t            weight_nxt [N_CH];
  val_t            pre_trace     [N_CH];
  val_t            pre_trace_nxt [N_CH];
  val_t            pot_snap     [N_CH];
  val_t            pot_snap_nxt [N_CH];
  val_t            dep_snap     [N_CH];
  val_t            dep_snap_nxt [N_CH];
  val_t            post_trace, post_trace_nxt;
  logic [N_CH-1:0] pot_pend, pot_pend_nxt;
  logic [N_CH-1:0] dep_pend, dep_pend_nxt;
  sum_t            isum;
  val_t            w_cur, w_upd;
  prod_t           pot, dep;
  acc_t            acc;

  function automatic val_t trace_step(input val_t t, input logic spike);
    val_t d;
    ext_t s;
    d = t - (t >> DECAY_SHIFT);
    s = ext_t'(d) + ext_t'(TRACE_INC);
    if (!spike)
      trace_step = d;
    else if (s > ext_t'(W_MAX))
      trace_step = W_MAX;
    else
      trace_step = s[TW-1:0];
  endfunction

  // Shared update datapath for the channel under the scan pointer.
  // The intermediate is wide enough to hold w + pot - dep exactly before clamping.
  always_comb begin
    w_cur = weight[idx];
    pot   = '0;
    dep   = '0;
    if (pot_pend[idx])
      pot = (prod_t'(pot_snap[idx]) * prod_t'(W_MAX - w_cur)) >> SH;
    if (dep_pend[idx])
      dep = (prod_t'(dep_snap[idx]) * prod_t'(w_cur)) >> SH;
    acc = acc_t'(w_cur) + acc_t'(pot) - acc_t'(dep);
    if (acc[PW+1])
      w_upd = '0;
    else if (|acc[PW:TW])
      w_upd = W_MAX;
    else
      w_upd = acc[TW-1:0];
  end

  always_comb begin
    weight_nxt     = weight;
    pre_trace_nxt  = pre_trace;
    pot_snap_nxt   = pot_snap;
    dep_snap_nxt   = dep_snap;
    pot_pend_nxt   = pot_pend;
    dep_pend_nxt   = dep_pend;
    post_trace_nxt = trace_step(post_trace, post_spike);
    state_nxt      = state;
    idx_nxt        = idx;

    // Clearing first lets an event arriving on the visited channel this cycle survive.
    if (state == SCAN) begin
      weight_nxt[idx]   = w_upd;
      pot_pend_nxt[idx] = 1'b0;
      dep_pend_nxt[idx] = 1'b0;
    end

    for (int unsigned i = 0; i < N_CH; i++) begin
      pre_trace_nxt[i] = trace_step(pre_trace[i], pre_spike[i]);
      if (pre_spike[i] && post_trace != '0) begin
        dep_pend_nxt[i] = 1'b1;
        dep_snap_nxt[i] = post_trace;
      end
      if (post_spike && pre_trace[i] != '0) begin
        pot_pend_nxt[i] = 1'b1;
        pot_snap_nxt[i] = pre_trace[i];
      end
    end

`ifdef STDP_WLOAD_EN
    // wr_data is TW bits wide, so it can never exceed W_MAX.
    if (wr_en) begin
      weight_nxt[wr_sel]   = wr_data;
      pot_pend_nxt[wr_sel] = 1'b0;
      dep_pend_nxt[wr_sel] = 1'b0;
    end
`endif

    case (state)
      IDLE: begin
        if (|(pot_pend | dep_pend)) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        if (idx == LAST) begin
          idx_nxt   = '0;
          state_nxt = (|(pot_pend_nxt | dep_pend_nxt)) ? SCAN : IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

`ifndef STDP_WLOAD_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_sel, wr_data};
`endif

  always_comb begin
    isum = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (pre_spike[i])
        isum = isum + sum_t'(weight[i] >> 2);
  end

  assign busy = (state == SCAN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      post_trace <= '0;
      pot_pend   <= '0;
      dep_pend   <= '0;
      i_syn      <= '0;
      rd_weight  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        weight[i]    <= val_t'(W_INIT);
        pre_trace[i] <= '0;
        pot_snap[i]  <= '0;
        dep_snap[i]  <= '0;
      end
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      post_trace <= post_trace_nxt;
      pot_pend   <= pot_pend_nxt;
      dep_pend   <= dep_pend_nxt;
      i_syn      <= isum;
      rd_weight  <= weight[rd_sel];
      for (int unsigned i = 0; i < N_CH; i++) begin
        weight[i]    <= weight_nxt[i];
        pre_trace[i] <= pre_trace_nxt[i];
        pot_snap[i]  <= pot_snap_nxt[i];
        dep_snap[i]  <= dep_snap_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array: vector table, directed corner sequences and a randomized run
// checked every cycle against a behavioural model of the learning rules.
module tb_stdp_synapse_array;

  localparam int N    = 4;
  localparam int WMAX = 2047;
  localparam int LRSH = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  pre_spike = '0;
  logic        post_spike = 1'b0;
  logic [13:0] i_syn;
  logic        busy;
  logic [1:0]  rd_sel = '0;
  logic [10:0] rd_weight;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [10:0] wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stdp_synapse_array #(
    .N_CH(4), .WIDTH(12), .FRAC(5), .W_INIT(32),
    .TRACE_INC(16), .DECAY_SHIFT(3), .LR_SHIFT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .i_syn(i_syn), .busy(busy), .rd_sel(rd_sel), .rd_weight(rd_weight),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data)
  );

  // Behavioural model state
  int m_w[N], m_pre_t[N], m_pot_s[N], m_dep_s[N];
  bit m_pot_p[N], m_dep_p[N];
  int m_post_t;
  bit m_scanning;
  int m_visit;
  int m_isyn, m_rd;

  typedef struct {
    logic [3:0] pre;
    logic       post;
    int         rsel;
    int         e_isyn;
    int         e_busy;
    int         e_rd;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decayed(input int t, input bit spike);
    int d;
    d = t - t / 8;
    if (spike) d = (d + 16 > WMAX) ? WMAX : d + 16;
    return d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i] = 32; m_pre_t[i] = 0; m_pot_s[i] = 0; m_dep_s[i] = 0;
      m_pot_p[i] = 0; m_dep_p[i] = 0;
    end
    m_post_t = 0; m_scanning = 0; m_visit = 0; m_isyn = 0; m_rd = 0;
  endfunction

  task automatic tick(input logic [3:0] p, input logic q, input int rs,
                      input logic we, input int ws, input int wd);
    int nw[N], npt[N], nps[N], nds[N];
    bit npp[N], ndp[N];
    int isum, pot, dep, tot, k;
    bit any_now, any_next;
    pre_spike = p; post_spike = q; rd_sel = rs[1:0];
    wr_en = we; wr_sel = ws[1:0]; wr_data = wd[10:0];

    isum = 0; any_now = 0;
    for (int i = 0; i < N; i++) begin
      nw[i] = m_w[i]; npt[i] = m_pre_t[i]; nps[i] = m_pot_s[i]; nds[i] = m_dep_s[i];
      npp[i] = m_pot_p[i]; ndp[i] = m_dep_p[i];
      if (p[i]) isum += m_w[i] / 4;
      if (m_pot_p[i] || m_dep_p[i]) any_now = 1;
    end
    if (m_scanning) begin
      k = m_visit;
      pot = m_pot_p[k] ? (m_pot_s[k] * (WMAX - m_w[k])) / (1 << LRSH) : 0;
      dep = m_dep_p[k] ? (m_dep_s[k] * m_w[k]) / (1 << LRSH) : 0;
      tot = m_w[k] + pot - dep;
      nw[k] = (tot < 0) ? 0 : (tot > WMAX) ? WMAX : tot;
      npp[k] = 0; ndp[k] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (p[i] && m_post_t > 0) begin ndp[i] = 1; nds[i] = m_post_t; end
      if (q && m_pre_t[i] > 0) begin npp[i] = 1; nps[i] = m_pre_t[i]; end
      npt[i] = decayed(m_pre_t[i], p[i]);
    end
`ifdef STDP_WLOAD_EN
    if (we) begin
      nw[ws] = (wd > WMAX) ? WMAX : wd;
      npp[ws] = 0; ndp[ws] = 0;
    end
`endif
    any_next = 0;
    for (int i = 0; i < N; i++) if (npp[i] || ndp[i]) any_next = 1;
    m_rd = m_w[rs];
    m_isyn = isum;
    m_post_t = decayed(m_post_t, q);
    if (!m_scanning) begin
      if (any_now) begin m_scanning = 1; m_visit = 0; end
    end else if (m_visit == N - 1) begin
      m_visit = 0; m_scanning = any_next;
    end else begin
      m_visit++;
    end
    for (int i = 0; i < N; i++) begin
      m_w[i] = nw[i]; m_pre_t[i] = npt[i]; m_pot_s[i] = nps[i]; m_dep_s[i] = nds[i];
      m_pot_p[i] = npp[i]; m_dep_p[i] = ndp[i];
    end

    @(posedge clk); #1;
    check("model_i_syn", int'(i_syn), m_isyn);
    check("model_busy", int'(busy), int'(m_scanning));
    check("model_rd_weight", int'(rd_weight), m_rd);
  endtask

  task automatic step(input logic [3:0] p, input logic q, input int rs);
    tick(p, q, rs, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    pre_spike = '0; post_spike = 1'b0; wr_en = 1'b0; rd_sel = '0;
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_i_syn", int'(i_syn), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_weight", int'(rd_weight), 0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    int n;
    step(4'b0000, 1'b0, 0);
    step(4'b0000, 1'b0, 0);
    n = 0;
    while (busy && n < 64) begin
      step(4'b0000, 1'b0, 0);
      n++;
    end
    check("drain_timeout_busy", int'(busy), 0);
  endtask

  task automatic readback(input int k, input int exp);
    step(4'b0000, 1'b0, k);
    check($sformatf("rd_w%0d", k), int'(rd_weight), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    logic [3:0] p;
    tbl[0] = '{4'b0001, 1'b0, 0,  8, 0,  32};
    tbl[1] = '{4'b0000, 1'b1, 0,  0, 0,  32};
    tbl[2] = '{4'b0000, 1'b0, 0,  0, 1,  32};
    tbl[3] = '{4'b0000, 1'b0, 0,  0, 1,  32};
    tbl[4] = '{4'b0000, 1'b0, 0,  0, 1, 283};
    tbl[5] = '{4'b0000, 1'b0, 0,  0, 1, 283};
    tbl[6] = '{4'b0000, 1'b0, 0,  0, 0, 283};
    tbl[7] = '{4'b0001, 1'b0, 0, 70, 0, 283};
    tbl[8] = '{4'b0000, 1'b0, 1,  0, 1,  32};

    model_reset();
    do_reset();
    for (int v = 0; v < 9; v++) begin
      step(tbl[v].pre, tbl[v].post, tbl[v].rsel);
      check($sformatf("tbl%0d_i_syn", v), int'(i_syn), tbl[v].e_isyn);
      check($sformatf("tbl%0d_busy", v), int'(busy), tbl[v].e_busy);
      check($sformatf("tbl%0d_rd", v), int'(rd_weight), tbl[v].e_rd);
    end

    // Depression: post then pre[2]
    do_reset();
    step(4'b0000, 1'b1, 0);
    step(4'b0100, 1'b0, 0);
    drain();
    readback(0, 32); readback(1, 32); readback(2, 28); readback(3, 32);

    // Lower bound: saturate post-trace, then depress channel 1 to zero twice
    do_reset();
    repeat (60) step(4'b0000, 1'b1, 0);
    step(4'b0010, 1'b0, 0);
    drain();
    readback(1, 0);
    step(4'b0010, 1'b0, 0);
    drain();
    readback(1, 0);

    // Upper bound: saturate pre-trace 3, potentiate to W_MAX twice
    do_reset();
    repeat (60) step(4'b1000, 1'b0, 0);
    step(4'b0000, 1'b1, 0);
    drain();
    readback(3, 2047);
    step(4'b0000, 1'b1, 0);
    drain();
    readback(3, 2047);
    step(4'b1000, 1'b0, 0);
    check("isyn_wmax", int'(i_syn), 511);

    // Second pass triggered by a post spike while channel 2 is being processed
    do_reset();
    busy_cnt = 0;
    step(4'b1111, 1'b0, 0); busy_cnt += int'(busy);
    step(4'b0000, 1'b1, 0); busy_cnt += int'(busy);
    repeat (3) begin step(4'b0000, 1'b0, 0); busy_cnt += int'(busy); end
    step(4'b0000, 1'b1, 0); busy_cnt += int'(busy);
    repeat (9) begin step(4'b0000, 1'b0, 0); busy_cnt += int'(busy); end
    check("two_pass_busy_cycles", busy_cnt, 8);
    readback(0, 434); readback(1, 434); readback(2, 434); readback(3, 205);

    // Host write colliding with the scheduled update of channel 3
    do_reset();
    step(4'b1000, 1'b0, 0);
    step(4'b0000, 1'b1, 0);
    repeat (4) step(4'b0000, 1'b0, 0);
    tick(4'b0000, 1'b0, 0, 1'b1, 3, 100);
    check("write_cycle_busy", int'(busy), 0);
    drain();
`ifdef STDP_WLOAD_EN
    readback(3, 100);
`else
    readback(3, 283);
`endif
    readback(0, 32);

    // Reset in the middle of a scan
    do_reset();
    step(4'b1111, 1'b0, 0);
    step(4'b0000, 1'b1, 0);
    step(4'b0000, 1'b0, 0);
    step(4'b0000, 1'b0, 0);
    check("midscan_busy_before", int'(busy), 1);
    do_reset();
    readback(0, 32);
    step(4'b0000, 1'b0, 0);
    check("midscan_busy_after", int'(busy), 0);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) p[b] = ($urandom_range(0, 3) == 0);
      tick(p, ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 2047));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
